axi_mem_arbiter: RTL
====================

Name: axi_mem_arbiter

Overview:
- Two-master to one-slave arbiter in front of the address-decoding crossbar.
- Shares the single 32-bit-address / 64-bit-data AXI-lite memory port between the instruction fetch unit (IFU, read only) and the load/store unit (LSU, read and write).
- Exactly one transaction is outstanding downstream at any time.
- Grant is held from address handshake to response handshake.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 64, data width; strobe width is DATA_W/8.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifu_arvalid, ifu_rready  in  1  IFU read request valid / read-data ready.
- ifu_araddr  in  ADDR_W  IFU read address.
- ifu_arready, ifu_rvalid  out  1  IFU address accepted / read data valid.
- ifu_rdata  out  DATA_W  IFU read data.
- ifu_rresp  out  2  IFU read response.
- lsu_arvalid, lsu_rready, lsu_awvalid, lsu_wvalid, lsu_bready  in  1  LSU channel valids/readys.
- lsu_araddr, lsu_awaddr  in  ADDR_W  LSU read / write addresses.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_wstrb  in  DATA_W/8  LSU write byte strobes.
- lsu_arready, lsu_rvalid, lsu_awready, lsu_wready, lsu_bvalid  out  1  LSU channel readys/valids.
- lsu_rdata  out  DATA_W  LSU read data.
- lsu_rresp, lsu_bresp  out  2  LSU responses.
- m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready  out  1  downstream valids/readys to crossbar.
- m_araddr, m_awaddr  out  ADDR_W  downstream addresses.
- m_wdata  out  DATA_W  downstream write data.
- m_wstrb  out  DATA_W/8  downstream strobes.
- m_arready, m_rvalid, m_awready, m_wready, m_bvalid  in  1  downstream readys/valids.
- m_rdata  in  DATA_W  downstream read data.
- m_rresp, m_bresp  in  2  downstream responses.

Behaviour:
- FSM states: IDLE, IFU_RD, LSU_RD, LSU_WR. Registered flags: ar_done, aw_done, w_done.
- Reset (reset=0, async):
  - state=IDLE, all flags 0.
  - Every valid/ready output 0; data/addr/resp outputs 0.
- Reset mid-transaction: all of the above take effect immediately; the in-flight downstream response is dropped. Slaves are reset on the same reset.
- IDLE arbitration (fixed priority): lsu_awvalid&lsu_wvalid -> LSU_WR; else lsu_arvalid -> LSU_RD; else ifu_arvalid -> IFU_RD. The grant is registered, so downstream valid appears 1 cycle after the request is seen.
- LSU_WR with only one of aw/w valid: no grant. Stay in IDLE unless a read can be granted.
- IFU_RD / LSU_RD:
  - m_arvalid = granted arvalid & ~ar_done; m_araddr = granted araddr.
  - Granted arready = m_arready & ~ar_done.
  - ar_done sets on the m_arvalid&m_arready handshake.
  - m_rready = granted rready. Granted rvalid/rdata/rresp = m_rvalid/m_rdata/m_rresp.
  - On m_rvalid&m_rready -> IDLE, clear ar_done.
- LSU_WR:
  - AW and W are forwarded independently, each gated by its own done flag. They may complete in either order or in the same cycle.
  - Once aw_done&w_done (or both handshaking this cycle), m_bready = lsu_bready and lsu_bvalid/bresp are forwarded.
  - On m_bvalid&m_bready -> IDLE, clear flags.
- Non-granted master: all of its ready/valid outputs 0, data/resp 0. Unused downstream channels: valids 0, addr/data 0.
- Turnaround: minimum 1 IDLE cycle between consecutive transactions. Back-to-back reads therefore take at least AR + R + 1 cycles.
- Requests arriving while busy wait. Masters must hold valid and address stable until their arready/awready (AXI rule; not checked).
- A master deasserting valid before grant is simply not granted.
- No widths are altered; all data, strobe and response fields pass through unmodified.

Optional Feature:
- Macro ARB_RR_EN.
- Defined: a 1-bit last_lsu register, set on every LSU grant and cleared on every IFU grant, reset 0. When IFU and any LSU request contend in IDLE, grant goes to the class not last served. Within LSU, write still beats read.
- Undefined: fixed priority as above; IFU can starve under continuous LSU traffic.

Test Plan:
- IFU read 0x30000000 alone, slave arready same cycle, rdata=0x1122334455667788 rresp=0 two cycles later -> ifu_rvalid with that data; LSU outputs stay 0; FSM back to IDLE the cycle after the R handshake.
- LSU write 0xa0000000 wdata=0xdeadbeef wstrb=0x0f, slave takes W one cycle before AW, bresp=0 -> exactly one m_wvalid and one m_awvalid handshake; lsu_bvalid forwarded only after both.
- IFU and LSU read requests in the same cycle -> LSU granted first, IFU granted in the IDLE following the LSU R handshake. With ARB_RR_EN and last_lsu=1 -> IFU granted first.
- LSU read and write valid together -> write completes (B handshake) before m_arvalid rises for the read.
- reset driven low while in LSU_RD with ar_done=1 -> all m_* valids and lsu_* outputs 0 immediately; after release a fresh IFU read completes normally.
- m_rresp=2'b10 on an IFU read -> ifu_rresp=2'b10 passed through; the arbiter still returns to IDLE.

Source files
------------

// File: rtl/axi_mem_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter, one transaction outstanding.
// Define ARB_RR_EN to alternate between IFU and LSU under contention instead of fixed LSU priority.
module axi_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_arvalid,
  input  logic                ifu_rready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_arready,
  output logic                ifu_rvalid,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  input  logic                lsu_arvalid,
  input  logic                lsu_rready,
  input  logic                lsu_awvalid,
  input  logic                lsu_wvalid,
  input  logic                lsu_bready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_arready,
  output logic                lsu_rvalid,
  output logic                lsu_awready,
  output logic                lsu_wready,
  output logic                lsu_bvalid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic [1:0]          lsu_bresp,
  output logic                m_arvalid,
  output logic                m_rready,
  output logic                m_awvalid,
  output logic                m_wvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_arready,
  input  logic                m_rvalid,
  input  logic                m_awready,
  input  logic                m_wready,
  input  logic                m_bvalid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic [1:0]          m_bresp
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_e;

  state_e state_q, state_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   aw_fin, w_fin;
  logic   lsu_wr_req, lsu_req, ifu_first;

  assign lsu_wr_req = lsu_awvalid & lsu_wvalid;
  assign lsu_req    = lsu_wr_req | lsu_arvalid;

`ifdef ARB_RR_EN
  logic last_lsu_q, last_lsu_d;
  assign ifu_first = ifu_arvalid & (~lsu_req | last_lsu_q);
`else
  assign ifu_first = ifu_arvalid & ~lsu_req;
`endif

  always_comb begin
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = '0;
    ifu_rresp   = '0;
    lsu_arready = 1'b0;
    lsu_rvalid  = 1'b0;
    lsu_rdata   = '0;
    lsu_rresp   = '0;
    lsu_awready = 1'b0;
    lsu_wready  = 1'b0;
    lsu_bvalid  = 1'b0;
    lsu_bresp   = '0;
    m_arvalid   = 1'b0;
    m_araddr    = '0;
    m_rready    = 1'b0;
    m_awvalid   = 1'b0;
    m_awaddr    = '0;
    m_wvalid    = 1'b0;
    m_wdata     = '0;
    m_wstrb     = '0;
    m_bready    = 1'b0;
    aw_fin      = 1'b0;
    w_fin       = 1'b0;
    case (state_q)
      IFU_RD: begin
        m_arvalid   = ifu_arvalid & ~ar_done_q;
        m_araddr    = ifu_araddr;
        ifu_arready = m_arready & ~ar_done_q;
        m_rready    = ifu_rready;
        ifu_rvalid  = m_rvalid;
        ifu_rdata   = m_rdata;
        ifu_rresp   = m_rresp;
      end
      LSU_RD: begin
        m_arvalid   = lsu_arvalid & ~ar_done_q;
        m_araddr    = lsu_araddr;
        lsu_arready = m_arready & ~ar_done_q;
        m_rready    = lsu_rready;
        lsu_rvalid  = m_rvalid;
        lsu_rdata   = m_rdata;
        lsu_rresp   = m_rresp;
      end
      LSU_WR: begin
        m_awvalid   = lsu_awvalid & ~aw_done_q;
        m_awaddr    = lsu_awaddr;
        lsu_awready = m_awready & ~aw_done_q;
        m_wvalid    = lsu_wvalid & ~w_done_q;
        m_wdata     = lsu_wdata;
        m_wstrb     = lsu_wstrb;
        lsu_wready  = m_wready & ~w_done_q;
        // B is only exposed once both AW and W have been accepted, possibly this very cycle
        aw_fin      = aw_done_q | (m_awvalid & m_awready);
        w_fin       = w_done_q | (m_wvalid & m_wready);
        if (aw_fin && w_fin) begin
          m_bready   = lsu_bready;
          lsu_bvalid = m_bvalid;
          lsu_bresp  = m_bresp;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
`ifdef ARB_RR_EN
    last_lsu_d = last_lsu_q;
`endif
    case (state_q)
      IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (ifu_first)        state_d = IFU_RD;
        else if (lsu_wr_req)  state_d = LSU_WR;
        else if (lsu_arvalid) state_d = LSU_RD;
`ifdef ARB_RR_EN
        if (ifu_first)    last_lsu_d = 1'b0;
        else if (lsu_req) last_lsu_d = 1'b1;
`endif
      end
      IFU_RD, LSU_RD: begin
        if (m_arvalid && m_arready) ar_done_d = 1'b1;
        if (m_rvalid && m_rready) begin
          state_d   = IDLE;
          ar_done_d = 1'b0;
        end
      end
      LSU_WR: begin
        if (m_awvalid && m_awready) aw_done_d = 1'b1;
        if (m_wvalid && m_wready)   w_done_d  = 1'b1;
        if (m_bvalid && m_bready) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ar_done_q  <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
`ifdef ARB_RR_EN
      last_lsu_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ar_done_q  <= ar_done_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
`ifdef ARB_RR_EN
      last_lsu_q <= last_lsu_d;
`endif
    end
  end

endmodule
